// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between byte-stream requesters.
// A grant is held until the owner's last byte completes or the per-grant watchdog expires.
`timescale 1ns/1ps

// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no owner; round-robin scan from ptr picks the next requester
// S_HOLD    | owner granted; waiting for its byte with the UART free
// S_WAIT_ACK| byte launched; waiting for the UART to raise tx_busy
// S_WAIT_DONE| frame on the wire; waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 grant_active,
  output logic                 timeout_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [WW-1:0] wd_cnt;
  logic          last_flag;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          accept;
  logic          wd_tc;
  logic [GW-1:0] next_ptr;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  assign accept   = (state == S_HOLD) && req_valid[grant_id] && !tx_busy;
  assign wd_tc    = (wd_cnt == '0);
  assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Watchdog is a down-counter loaded with TIMEOUT_CYCLES-1 on entry to a
  // stallable state; terminal count on a stalled cycle releases the grant.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      wd_cnt       <= '0;
      last_flag    <= 1'b0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id     <= pick_idx;
            grant_active <= 1'b1;
            wd_cnt       <= WD_LOAD;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            tx_data   <= req_data[8*grant_id +: 8];
            last_flag <= req_last[grant_id];
            tx_start  <= 1'b1;
            wd_cnt    <= WD_LOAD;
            state     <= S_WAIT_ACK;
          end else if (wd_tc) begin
            grant_active <= 1'b0;
            ptr          <= next_ptr;
            timeout_err  <= 1'b1;
            state        <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (wd_tc) begin
            grant_active <= 1'b0;
            ptr          <= next_ptr;
            timeout_err  <= 1'b1;
            state        <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant_active <= 1'b0;
              ptr          <= next_ptr;
              state        <= S_IDLE;
            end else begin
              wd_cnt <= WD_LOAD;
              state  <= S_HOLD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk_50mhz) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART busy model and grant/byte logs.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  logic        clk_50mhz = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        grant_active;
  logic        timeout_err;

  logic        uart_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic        pend = 1'b0;
  int          busy_cnt = 0;
  logic        prev_ga = 1'b0;
  logic [7:0]  tx_log[$];
  logic [1:0]  grant_log[$];

  int checks = 0;
  int errors = 0;
  logic watch_r1 = 1'b0;
  logic r1_early = 1'b0;

  assign tx_busy = uart_busy | force_busy;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_50mhz    (clk_50mhz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .timeout_err  (timeout_err)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // UART model: busy rises one cycle after tx_start and stays high 10 cycles; logs bytes and grants.
  always @(negedge clk_50mhz) begin
    if (tx_start) begin
      pend = 1'b1;
      tx_log.push_back(tx_data);
    end else if (pend) begin
      pend = 1'b0;
      uart_busy = 1'b1;
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
    if (grant_active && !prev_ga) grant_log.push_back(grant_id);
    prev_ga = grant_active;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_50mhz);
    #1;
    if (watch_r1 && req_ready[1]) r1_early = 1'b1;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b, input logic last, input string tag);
    logic got;
    got = 1'b0;
    req_data[8*idx +: 8] = b;
    req_last[idx] = last;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ready"}, 32'(got), 32'd1);
    cyc();
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(b));
  endtask

  task automatic wait_busy_fall(input string tag);
    logic seen_high;
    logic done;
    seen_high = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (tx_busy) seen_high = 1'b1;
      else if (seen_high) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_busy_fall"}, 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!grant_active && !tx_busy && !pend) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(done), 32'd1);
    tx_log.delete();
    grant_log.delete();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;

    // reset values
    repeat (3) @(posedge clk_50mhz);
    #1;
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    cyc();

    // single-byte packet from requester 2
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'hA5;
    req_last[2] = 1'b1;
    cyc();
    chk("t1_grant_active", 32'(grant_active), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    chk("t1_ready", 32'(req_ready), 32'h4);
    cyc();
    chk("t1_tx_start", 32'(tx_start), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_ready_off", 32'(req_ready), 32'd0);
    req_valid = '0;
    req_last = '0;
    wait_busy_fall("t1");
    chk("t1_release", 32'(grant_active), 32'd0);
    chk("t1_tx_count", 32'(tx_log.size()), 32'd1);
    chk("t1_log_data", 32'(tx_log[0]), 32'hA5);
    chk("t1_tx_data_hold", 32'(tx_data), 32'hA5);
    wait_idle("t1");

    // packet lock: requester 0 sends 3 bytes while requester 1 waits (ptr=3 -> 0 first)
    req_data[15:8] = 8'h44;
    req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    watch_r1 = 1'b1;
    r1_early = 1'b0;
    send_byte(0, 8'h11, 1'b0, "t2_b0");
    send_byte(0, 8'h22, 1'b0, "t2_b1");
    send_byte(0, 8'h33, 1'b1, "t2_b2");
    req_valid[0] = 1'b0;
    watch_r1 = 1'b0;
    chk("t2_r1_locked_out", 32'(r1_early), 32'd0);
    send_byte(1, 8'h44, 1'b1, "t2_r1");
    chk("t2_r1_grant", 32'(grant_id), 32'd1);
    req_valid = '0;
    req_last = '0;
    begin
      logic [7:0] exp2[4];
      exp2 = '{8'h11, 8'h22, 8'h33, 8'h44};
      repeat (2) cyc();
      chk("t2_count", 32'(tx_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < tx_log.size(); i++) chk($sformatf("t2_byte%0d", i), 32'(tx_log[i]), 32'(exp2[i]));
    end
    wait_idle("t2");

    // round-robin after a fresh reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tx_log.delete();
    grant_log.delete();
    req_data = 32'hC3C2C1C0;
    req_last = 4'hF;
    req_valid = 4'hF;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (grant_log.size() >= 6) break;
    end
    req_valid = '0;
    chk("t3_grants", 32'(grant_log.size()), 32'd6);
    repeat (2) cyc();
    begin
      logic [1:0] expg[6];
      expg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
        chk($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(expg[i]));
        if (i < tx_log.size()) chk($sformatf("t3_byte%0d", i), 32'(tx_log[i]), 32'(8'hC0 + 8'(expg[i])));
      end
    end
    req_last = '0;
    wait_idle("t3");

    // watchdog: requester 3 stalls after a non-last byte, requester 0 pending (ptr=2)
    send_byte(3, 8'h5A, 1'b0, "t4_b0");
    req_valid[3] = 1'b0;
    req_data[7:0] = 8'h77;
    req_last[0] = 1'b1;
    req_valid[0] = 1'b1;
    wait_busy_fall("t4");
    begin
      logic early;
      early = 1'b0;
      repeat (15) begin
        cyc();
        if (timeout_err || !grant_active) early = 1'b1;
      end
      chk("t4_no_early_timeout", 32'(early), 32'd0);
    end
    cyc();
    chk("t4_timeout_pulse", 32'(timeout_err), 32'd1);
    chk("t4_released", 32'(grant_active), 32'd0);
    cyc();
    chk("t4_pulse_end", 32'(timeout_err), 32'd0);
    chk("t4_regrant", 32'(grant_active), 32'd1);
    chk("t4_regrant_id", 32'(grant_id), 32'd0);
    chk("t4_ready0", 32'(req_ready), 32'h1);
    cyc();
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_data", 32'(tx_data), 32'h77);
    req_valid = '0;
    req_last = '0;
    wait_idle("t4");

    // busy stall: UART busy when requester 1 asks (ptr=1)
    force_busy = 1'b1;
    req_data[15:8] = 8'h3C;
    req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    cyc();
    chk("t5_grant_active", 32'(grant_active), 32'd1);
    chk("t5_grant_id", 32'(grant_id), 32'd1);
    begin
      logic leak;
      leak = (req_ready != 4'h0);
      repeat (3) begin
        cyc();
        if (req_ready != 4'h0) leak = 1'b1;
      end
      chk("t5_ready_held", 32'(leak), 32'd0);
    end
    force_busy = 1'b0;
    #1;
    chk("t5_ready_on", 32'(req_ready), 32'h2);
    cyc();
    chk("t5_start", 32'(tx_start), 32'd1);
    chk("t5_data", 32'(tx_data), 32'h3C);
    req_valid = '0;
    req_last = '0;
    wait_idle("t5");

    // reset in WAIT_DONE of byte 2 of 4 (ptr=2 beforehand)
    send_byte(0, 8'hD1, 1'b0, "t6_b0");
    send_byte(0, 8'hD2, 1'b0, "t6_b1");
    begin
      logic hi;
      hi = 1'b0;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (tx_busy) begin
          hi = 1'b1;
          break;
        end
      end
      chk("t6_in_wait_done", 32'(hi), 32'd1);
    end
    cyc();
    req_data[7:0] = 8'hD3;
    req_data[23:16] = 8'hEE;
    req_last[2] = 1'b1;
    req_valid[2] = 1'b1;
    cyc();
    chk("t6_locked", 32'(grant_id), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_rst_grant_active", 32'(grant_active), 32'd0);
    chk("t6_rst_grant_id", 32'(grant_id), 32'd0);
    chk("t6_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_timeout", 32'(timeout_err), 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("t6_regrant", 32'(grant_active), 32'd1);
    chk("t6_regrant_id", 32'(grant_id), 32'd0);
    req_valid = '0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
